sram_banked_xbar: RTL and testbench

//  Parametrised multi-port, multi-bank on-chip SRAM with OBI slave ports; successor to the fixed 2-port SoC SRAM wrapper.
//  N_PORTS OBI masters (core I/D, DMA, ...) share N_BANKS single-port banks through per-bank round-robin arbitration.

---
 rtl/sram_xbar_pkg.sv | 35 +++
 rtl/sram_rr_arb.sv | 41 ++++
 rtl/sram_banked_xbar.sv | 172 +++++++++++++++++
 tb/tb_sram_banked_xbar.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sram_xbar_pkg.sv
// rtl/sram_xbar_pkg.sv - shared types, constants and address helpers for sram_banked_xbar
//   obi_req_t  : one OBI request beat {addr, we, be, wdata}
//   obi_rsp_t  : one OBI response beat {rdata, err}
//   DEADBEEF_C : read data returned for out-of-range accesses
//   bank_of()  : bank index of a word offset (contiguous or interleaved)
//   row_of()   : row within that bank
package sram_xbar_pkg;

  localparam logic [31:0] DEADBEEF_C = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_rsp_t;

  function automatic logic [31:0] bank_of(input logic [31:0] word, input int unsigned n_banks,
                                          input int unsigned bank_words, input bit interleave);
    if (interleave) return word % n_banks;
    return word / bank_words;
  endfunction

  function automatic logic [31:0] row_of(input logic [31:0] word, input int unsigned n_banks,
                                         input int unsigned bank_words, input bit interleave);
    if (interleave) return word / n_banks;
    return word % bank_words;
  endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// rtl/sram_rr_arb.sv - round-robin arbiter, one-hot grant, pointer advances on grant
//   clk_i, rst_i : clock, synchronous active-high reset (pointer -> 0)
//   req_i [N]    : request vector
//   gnt_o [N]    : one-hot grant, combinational from req_i
module sram_rr_arb #(
  parameter int unsigned N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  int unsigned   idx;
  logic          found;

  // Scan starting at the pointer; the pointer holds the port after the last winner.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_q) + i) % N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = PW'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_banked_xbar.sv
// rtl/sram_banked_xbar.sv - multi-port multi-bank SRAM with OBI slave ports and per-bank RR arbitration
//   Optional feature macro: SRAM_ERR_RESP_EN (adds err_o)
//   clk_i, rst_i      : clock, synchronous active-high reset
//   req_i/gnt_o       : OBI handshake per port (gnt combinational)
//   addr_i/we_i/be_i/wdata_i : OBI request payload per port
//   rvalid_o/rdata_o  : response one cycle after grant
//   err_o             : out-of-range response flag (SRAM_ERR_RESP_EN only)
//   illegal_access_o  : pulses with any out-of-range response
module sram_banked_xbar
  import sram_xbar_pkg::*;
#(
  parameter int unsigned N_PORTS    = 2,
  parameter int unsigned N_BANKS    = 24,
  parameter int unsigned BANK_WORDS = 512,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter bit          INTERLEAVE = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_PORTS-1:0]       req_i,
  output logic [N_PORTS-1:0]       gnt_o,
  input  logic [N_PORTS-1:0][31:0] addr_i,
  input  logic [N_PORTS-1:0]       we_i,
  input  logic [N_PORTS-1:0][3:0]  be_i,
  input  logic [N_PORTS-1:0][31:0] wdata_i,
  output logic [N_PORTS-1:0]       rvalid_o,
  output logic [N_PORTS-1:0][31:0] rdata_o,
`ifdef SRAM_ERR_RESP_EN
  output logic [N_PORTS-1:0]       err_o,
`endif
  output logic                     illegal_access_o
);

  localparam logic [31:0] SIZE_BYTES = 32'(N_BANKS * BANK_WORDS * 4);
  localparam int unsigned BW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam int unsigned RW = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;

  obi_req_t [N_PORTS-1:0]          preq;
  logic     [N_PORTS-1:0][31:0]    off;
  logic     [N_PORTS-1:0]          in_range;
  logic     [N_PORTS-1:0][BW-1:0]  bank_sel;
  logic     [N_PORTS-1:0][RW-1:0]  row_sel;

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      preq[p]     = '{addr: addr_i[p], we: we_i[p], be: be_i[p], wdata: wdata_i[p]};
      off[p]      = preq[p].addr - BASE_ADDR;
      in_range[p] = (preq[p].addr >= BASE_ADDR) && (off[p] < SIZE_BYTES);
      bank_sel[p] = BW'(bank_of({2'b00, off[p][31:2]}, N_BANKS, BANK_WORDS, INTERLEAVE));
      row_sel[p]  = RW'(row_of({2'b00, off[p][31:2]}, N_BANKS, BANK_WORDS, INTERLEAVE));
    end
  end

  logic [N_BANKS-1:0][N_PORTS-1:0] bank_req, bank_gnt;
  logic [31:0]                     bank_dout [N_BANKS];

  always_comb begin
    bank_req = '0;
    for (int b = 0; b < N_BANKS; b++)
      for (int p = 0; p < N_PORTS; p++)
        bank_req[b][p] = !rst_i && req_i[p] && in_range[p] && (bank_sel[p] == BW'(b));
  end

  // Out-of-range requests need no bank, so they are granted unconditionally.
  always_comb begin
    gnt_o = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      gnt_o[p] = !rst_i && req_i[p] && !in_range[p];
      for (int b = 0; b < N_BANKS; b++) gnt_o[p] = gnt_o[p] | bank_gnt[b][p];
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [31:0]   mem_q [BANK_WORDS];
    logic [31:0]   dout_q;
    logic          bank_en, bank_we;
    logic [3:0]    bank_be;
    logic [31:0]   bank_wdata;
    logic [RW-1:0] bank_row;

    sram_rr_arb #(.N(N_PORTS)) u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i (bank_req[b]),
      .gnt_o (bank_gnt[b])
    );

    always_comb begin
      bank_en    = 1'b0;
      bank_we    = 1'b0;
      bank_be    = '0;
      bank_wdata = '0;
      bank_row   = '0;
      for (int p = 0; p < N_PORTS; p++) begin
        if (bank_gnt[b][p]) begin
          bank_en    = 1'b1;
          bank_we    = preq[p].we;
          bank_be    = preq[p].be;
          bank_wdata = preq[p].wdata;
          bank_row   = row_sel[p];
        end
      end
    end

    // Contents survive reset; only the response path is cleared.
    always_ff @(posedge clk_i) begin
      if (bank_en) begin
        if (bank_we) begin
          for (int i = 0; i < 4; i++)
            if (bank_be[i]) mem_q[bank_row][8*i +: 8] <= bank_wdata[8*i +: 8];
        end else begin
          dout_q <= mem_q[bank_row];
        end
      end
    end

    assign bank_dout[b] = dout_q;
  end

  logic [N_PORTS-1:0]         rsp_valid_q, rsp_valid_d;
  logic [N_PORTS-1:0]         rsp_oob_q, rsp_oob_d;
  logic [N_PORTS-1:0]         rsp_we_q, rsp_we_d;
  logic [N_PORTS-1:0][BW-1:0] rsp_bank_q, rsp_bank_d;

  always_comb begin
    rsp_valid_d = gnt_o;
    rsp_oob_d   = ~in_range;
    rsp_we_d    = we_i;
    rsp_bank_d  = bank_sel;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= '0;
      rsp_oob_q   <= '0;
      rsp_we_q    <= '0;
      rsp_bank_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_oob_q   <= rsp_oob_d;
      rsp_we_q    <= rsp_we_d;
      rsp_bank_q  <= rsp_bank_d;
    end
  end

  // A response still in flight when reset rises is suppressed immediately.
  obi_rsp_t [N_PORTS-1:0] rsp;

  always_comb begin
    rvalid_o         = '0;
    rdata_o          = '0;
    rsp              = '0;
    illegal_access_o = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (rsp_valid_q[p] && !rst_i) begin
        rvalid_o[p] = 1'b1;
        if (rsp_oob_q[p]) rsp[p] = '{rdata: DEADBEEF_C, err: 1'b1};
        else if (!rsp_we_q[p]) rsp[p].rdata = bank_dout[rsp_bank_q[p]];
      end
      rdata_o[p]       = rsp[p].rdata;
      illegal_access_o = illegal_access_o | rsp[p].err;
    end
  end

`ifdef SRAM_ERR_RESP_EN
  always_comb begin
    err_o = '0;
    for (int p = 0; p < N_PORTS; p++) err_o[p] = rsp[p].err;
  end
`endif

endmodule

// File: tb/tb_sram_banked_xbar.sv
// tb/tb_sram_banked_xbar.sv - vector table plus response scoreboard for sram_banked_xbar
module tb_sram_banked_xbar;
  import sram_xbar_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SIZE = 32'h0000_C000;

  typedef struct packed {
    bit          rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] d1;
    logic [1:0]  gnt;
  } vec_t;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        oob;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req = '0, gnt, we = '0, rvalid;
  logic [1:0][31:0] addr = '0, wdata = '0, rdata;
  logic [1:0][3:0]  be = '0;
  logic             illegal;
`ifdef SRAM_ERR_RESP_EN
  logic [1:0]       err;
`endif

  int checks = 0;
  int errors = 0;

  exp_t        sb_q[$];
  logic [31:0] model_mem [logic [31:0]];
  vec_t        vecs[$];

  always #5 clk = ~clk;

  sram_banked_xbar dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_i            (req),
    .gnt_o            (gnt),
    .addr_i           (addr),
    .we_i             (we),
    .be_i             (be),
    .wdata_i          (wdata),
    .rvalid_o         (rvalid),
    .rdata_o          (rdata),
`ifdef SRAM_ERR_RESP_EN
    .err_o            (err),
`endif
    .illegal_access_o (illegal)
  );

  function automatic vec_t mk(bit r, logic [1:0] rq, logic [1:0] w,
                              logic [31:0] a0, logic [3:0] b0, logic [31:0] d0,
                              logic [31:0] a1, logic [3:0] b1, logic [31:0] d1, logic [1:0] g);
    vec_t v;
    v = '{rst: r, req: rq, we: w, a0: a0, be0: b0, d0: d0, a1: a1, be1: b1, d1: d1, gnt: g};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected response of a granted beat, computed from the bench's own memory model.
  task automatic push_exp(input int p, input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] d);
    exp_t        e;
    logic [31:0] word, cur;
    e.port  = p[0];
    e.oob   = !((a >= BASE) && ((a - BASE) < SIZE));
    e.rdata = 32'h0;
    word    = a >> 2;
    if (e.oob) begin
      e.rdata = 32'hDEAD_BEEF;
    end else if (w) begin
      cur = model_mem.exists(word) ? model_mem[word] : 32'h0;
      for (int i = 0; i < 4; i++) if (b[i]) cur[8*i +: 8] = d[8*i +: 8];
      model_mem[word] = cur;
    end else begin
      e.rdata = model_mem.exists(word) ? model_mem[word] : 32'h0;
    end
    sb_q.push_back(e);
  endtask

  task automatic check_rsp(input int n);
    logic [1:0]       ev, eo;
    logic [1:0][31:0] ed;
    exp_t             e;
    ev = '0; eo = '0; ed = '0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (!rst) begin
        ev[e.port] = 1'b1;
        ed[e.port] = e.rdata;
        eo[e.port] = e.oob;
      end
    end
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("v%0d rvalid[%0d]", n, p), 32'(rvalid[p]), 32'(ev[p]));
      chk($sformatf("v%0d rdata[%0d]", n, p), rdata[p], ed[p]);
    end
    chk($sformatf("v%0d illegal", n), 32'(illegal), 32'(|eo));
`ifdef SRAM_ERR_RESP_EN
    chk($sformatf("v%0d err", n), 32'(err), 32'(eo));
`endif
  endtask

  task automatic apply(input vec_t v, input int n);
    @(posedge clk);
    #1;
    rst      = v.rst;
    req      = v.req;
    we       = v.we;
    addr[0]  = v.a0;  be[0] = v.be0; wdata[0] = v.d0;
    addr[1]  = v.a1;  be[1] = v.be1; wdata[1] = v.d1;
    @(negedge clk);
    check_rsp(n);
    chk($sformatf("v%0d gnt", n), 32'(gnt), 32'(v.gnt));
    if (v.gnt[0]) push_exp(0, v.a0, v.we[0], v.be0, v.d0);
    if (v.gnt[1]) push_exp(1, v.a1, v.we[1], v.be1, v.d1);
  endtask

  initial begin
    // reset, with requests held to show gnt is forced low
    vecs.push_back(mk(1, 2'b11, 2'b00, 32'h8000_0000, 4'h0, 0, 32'h8000_0800, 4'h0, 0, 2'b00));
    vecs.push_back(mk(1, 2'b11, 2'b00, 32'h8000_0000, 4'h0, 0, 32'h8000_0800, 4'h0, 0, 2'b00));
    // single-port write then read-back
    vecs.push_back(mk(0, 2'b01, 2'b01, 32'h8000_0010, 4'hF, 32'hCAFE_F00D, 0, 4'h0, 0, 2'b01));
    vecs.push_back(mk(0, 2'b01, 2'b00, 32'h8000_0010, 4'h0, 0, 0, 4'h0, 0, 2'b01));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, 4'h0, 0, 0, 4'h0, 0, 2'b00));
    // different banks in parallel
    vecs.push_back(mk(0, 2'b11, 2'b11, 32'h8000_0000, 4'hF, 32'h1111_1111, 32'h8000_0800, 4'hF, 32'h2222_2222, 2'b11));
    vecs.push_back(mk(0, 2'b11, 2'b00, 32'h8000_0000, 4'h0, 0, 32'h8000_0800, 4'h0, 0, 2'b11));
    vecs.push_back(mk(0, 2'b11, 2'b01, 32'h8000_0004, 4'hF, 32'h3333_3333, 32'h8000_0800, 4'h0, 0, 2'b11));
    vecs.push_back(mk(0, 2'b11, 2'b00, 32'h8000_0004, 4'h0, 0, 32'h8000_0800, 4'h0, 0, 2'b11));
    // same-bank conflict on bank 2, pointer left at P0 by a P1 write
    vecs.push_back(mk(0, 2'b10, 2'b10, 0, 4'h0, 0, 32'h8000_1000, 4'hF, 32'h4444_4444, 2'b10));
    vecs.push_back(mk(0, 2'b11, 2'b00, 32'h8000_1000, 4'h0, 0, 32'h8000_1000, 4'h0, 0, 2'b01));
    vecs.push_back(mk(0, 2'b11, 2'b00, 32'h8000_1000, 4'h0, 0, 32'h8000_1000, 4'h0, 0, 2'b10));
    vecs.push_back(mk(0, 2'b11, 2'b00, 32'h8000_1000, 4'h0, 0, 32'h8000_1000, 4'h0, 0, 2'b01));
    // range edges: first byte past end, last word, below base
    vecs.push_back(mk(0, 2'b11, 2'b10, 32'h8000_C000, 4'h0, 0, 32'h8000_BFFC, 4'hF, 32'h5555_5555, 2'b11));
    vecs.push_back(mk(0, 2'b11, 2'b00, 32'h8000_BFFC, 4'h0, 0, 32'h7FFF_FFFC, 4'h0, 0, 2'b11));
    // byte enables, be=0 no-op, cross-port read of previous-cycle write
    vecs.push_back(mk(0, 2'b01, 2'b01, 32'h8000_0020, 4'hF, 32'h1122_3344, 0, 4'h0, 0, 2'b01));
    vecs.push_back(mk(0, 2'b01, 2'b01, 32'h8000_0020, 4'b0010, 32'hAABB_CCDD, 0, 4'h0, 0, 2'b01));
    vecs.push_back(mk(0, 2'b01, 2'b01, 32'h8000_0020, 4'b0000, 32'hFFFF_FFFF, 0, 4'h0, 0, 2'b01));
    vecs.push_back(mk(0, 2'b01, 2'b00, 32'h8000_0020, 4'h0, 0, 0, 4'h0, 0, 2'b01));
    vecs.push_back(mk(0, 2'b10, 2'b10, 0, 4'h0, 0, 32'h8000_0024, 4'hF, 32'h5A5A_5A5A, 2'b10));
    vecs.push_back(mk(0, 2'b11, 2'b00, 32'h8000_0024, 4'h0, 0, 32'h8000_0020, 4'h0, 0, 2'b01));
    vecs.push_back(mk(0, 2'b10, 2'b00, 0, 4'h0, 0, 32'h8000_0020, 4'h0, 0, 2'b10));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, 4'h0, 0, 0, 4'h0, 0, 2'b00));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // reset right after a grant drops the response, resets RR pointers, keeps memory
    apply(mk(0, 2'b01, 2'b00, 32'h8000_0010, 4'h0, 0, 0, 4'h0, 0, 2'b01), 100);
    apply(mk(1, 2'b11, 2'b00, 32'h8000_1000, 4'h0, 0, 32'h8000_1000, 4'h0, 0, 2'b00), 101);
    apply(mk(1, 2'b11, 2'b00, 32'h8000_1000, 4'h0, 0, 32'h8000_1000, 4'h0, 0, 2'b00), 102);
    apply(mk(0, 2'b11, 2'b00, 32'h8000_1000, 4'h0, 0, 32'h8000_1000, 4'h0, 0, 2'b01), 103);
    apply(mk(0, 2'b11, 2'b00, 32'h8000_1000, 4'h0, 0, 32'h8000_1000, 4'h0, 0, 2'b10), 104);
    apply(mk(0, 2'b01, 2'b00, 32'h8000_0010, 4'h0, 0, 0, 4'h0, 0, 2'b01), 105);
    apply(mk(0, 2'b00, 2'b00, 0, 4'h0, 0, 0, 4'h0, 0, 2'b00), 106);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
